// File: rtl/clock_ratio_meter_pkg.sv
// Shared definitions for clock_ratio_meter: FSM state encoding and parameter defaults.
package clock_ratio_meter_pkg;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_TIMEOUT_CYC = 16777215;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_HIGH      = 3'd3,
        S_LOW       = 3'd4
    } state_t;

endpackage

// File: rtl/clock_ratio_meter_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, plus one-cycle rise/fall pulses
// taken from the synchronised value and its registered copy.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta, s, s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
        end else begin
            meta <= sig;
            s    <= meta;
            s_d  <= s;
        end
    end

    assign level = s;
    assign rise  = s & ~s_d;
    assign fall  = ~s & s_d;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures high-phase length and period of a slow asynchronous signal in i_clk cycles,
// one measurement per i_start, with a per-edge wait timeout.
module clock_ratio_meter
    import clock_ratio_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_sig,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_high,
    output logic [CNT_W-1:0] o_period
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(TIMEOUT_CYC);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   hi_len_q, hi_len_d;
    logic [CNT_W-1:0]   high_d, period_d;
    logic [CNT_W-1:0]   cnt_inc, wait_inc;
    logic               valid_d, timeout_d;
    logic               lvl, rise, fall;
    logic               time_up, abort;

    sync_edge_detect u_sync (
        .clk   (i_clk),
        .rst   (rst),
        .sig   (i_sig),
        .level (lvl),
        .rise  (rise),
        .fall  (fall)
    );

    // Saturating increments; the timeout always fires before the wait counter could saturate.
    assign cnt_inc  = (cnt_q  == CNT_MAX) ? cnt_q  : cnt_q  + CNT_W'(1);
    assign wait_inc = (wait_q == CNT_MAX) ? wait_q : wait_q + CNT_W'(1);
    assign time_up  = (wait_q >= WAIT_LIM);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_inc;
        hi_len_d  = hi_len_q;
        high_d    = o_high;
        period_d  = o_period;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (i_start) state_d = S_ARM;
            end
            S_ARM: begin
                // Never start on a high phase already in progress.
                if (!lvl) begin
                    state_d = S_WAIT_RISE;
                    wait_d  = '0;
                end else if (time_up) begin
                    abort = 1'b1;
                end
            end
            S_WAIT_RISE: begin
                if (rise) begin
                    state_d = S_HIGH;
                    cnt_d   = CNT_W'(1);
                    wait_d  = '0;
                end else if (time_up) begin
                    abort = 1'b1;
                end
            end
            S_HIGH: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    hi_len_d = cnt_q;
                    state_d  = S_LOW;
                    wait_d   = '0;
                end else if (time_up) begin
                    abort = 1'b1;
                end
            end
            S_LOW: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hi_len_q;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                    wait_d   = '0;
                end else if (time_up) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = '0;
            end
        endcase
        if (abort) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
            wait_d    = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            hi_len_q  <= '0;
            o_high    <= '0;
            o_period  <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            hi_len_q  <= hi_len_d;
            o_high    <= high_d;
            o_period  <= period_d;
            o_valid   <= valid_d;
            o_timeout <= timeout_d;
        end
    end

    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Bench for clock_ratio_meter: table of square waves plus hand sequences for timeout,
// reset mid-measurement, back-to-back and ignored restarts; results checked via a scoreboard queue.
module tb_clock_ratio_meter;

    localparam int CW = 16;
    localparam int TO = 100;

    logic          i_clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_sig = 1'b0;
    logic          i_start = 1'b0;
    logic          o_busy, o_valid, o_timeout;
    logic [CW-1:0] o_high, o_period;

    always #5 i_clk = ~i_clk;

    clock_ratio_meter #(.CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
        .i_clk     (i_clk),
        .rst       (rst),
        .i_sig     (i_sig),
        .i_start   (i_start),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_timeout (o_timeout),
        .o_high    (o_high),
        .o_period  (o_period)
    );

    typedef struct {
        bit            to;
        logic [CW-1:0] high;
        logic [CW-1:0] period;
    } exp_t;

    typedef struct {
        int hi;
        int lo;
        bit st_hi;
        bit to;
        int eh;
        int ep;
    } vec_t;

    exp_t          sb[$];
    vec_t          vt[11];
    int            n_vec = 0;
    int            n_err = 0;
    logic [CW-1:0] last_high = '0;
    logic [CW-1:0] last_period = '0;

    // Signal generator: square wave (sq_hi high, sq_lo low) or constant level, updated on negedge.
    bit   sq_en = 1'b0;
    int   sq_hi = 1;
    int   sq_lo = 1;
    int   ph = 0;
    logic lvl = 1'b0;

    initial begin
        forever begin
            @(negedge i_clk);
            if (sq_en) begin
                i_sig = (ph < sq_hi);
                ph = (ph + 1 >= sq_hi + sq_lo) ? 0 : ph + 1;
            end else begin
                i_sig = lvl;
            end
        end
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    always @(negedge i_clk) begin
        if (rst === 1'b0 && (o_valid === 1'b1 || o_timeout === 1'b1)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: valid=%0b timeout=%0b with nothing pending", o_valid, o_timeout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind_timeout", 32'(o_timeout), 32'(e.to));
                chk("pulse_kind_valid", 32'(o_valid), 32'(!e.to));
                chk("o_high", 32'(o_high), 32'(e.high));
                chk("o_period", 32'(o_period), 32'(e.period));
                chk("busy_at_result", 32'(o_busy), 32'd0);
            end
        end
    end

    task automatic cfg_const(input logic v);
        @(posedge i_clk);
        #1;
        sq_en = 1'b0;
        lvl = v;
    endtask

    task automatic cfg_wave(input int h, input int l);
        @(posedge i_clk);
        #1;
        sq_hi = h;
        sq_lo = l;
        ph = 0;
        sq_en = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic expect_valid(input int h, input int p);
        exp_t e;
        e.to = 1'b0;
        e.high = CW'(h);
        e.period = CW'(p);
        sb.push_back(e);
        last_high = CW'(h);
        last_period = CW'(p);
    endtask

    task automatic expect_timeout();
        exp_t e;
        e.to = 1'b1;
        e.high = last_high;
        e.period = last_period;
        sb.push_back(e);
    endtask

    task automatic drain(input string nm);
        int c = 0;
        while (sb.size() != 0 && c < 800) begin
            @(negedge i_clk);
            c++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no result within %0d cycles, %0d pending", nm, c, sb.size());
            sb.delete();
        end
    endtask

    task automatic settle_low();
        cfg_const(1'b0);
        repeat (6) @(posedge i_clk);
    endtask

    task automatic run_vec(input vec_t v);
        settle_low();
        cfg_wave(v.hi, v.lo);
        if (v.st_hi) repeat (3) @(posedge i_clk);
        if (v.to) expect_timeout();
        else expect_valid(v.eh, v.ep);
        pulse_start();
        drain($sformatf("vec_%0d_%0d", v.hi, v.lo));
    endtask

    task automatic timeout_latency(input logic level, input int exp_cyc, input string nm);
        int c;
        cfg_const(level);
        repeat (6) @(posedge i_clk);
        expect_timeout();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        c = 1;
        while (o_timeout !== 1'b1 && c < 300) begin
            @(negedge i_clk);
            c++;
        end
        chk(nm, 32'(c), 32'(exp_cyc));
        drain(nm);
    endtask

    initial begin
        int c;
        vt[0]  = '{1,   2,   1'b0, 1'b0, 1,   3};
        vt[1]  = '{1,   5,   1'b0, 1'b0, 1,   6};
        vt[2]  = '{7,   5,   1'b1, 1'b0, 7,   12};
        vt[3]  = '{3,   3,   1'b0, 1'b0, 3,   6};
        vt[4]  = '{5,   1,   1'b1, 1'b0, 5,   6};
        vt[5]  = '{1,   1,   1'b0, 1'b0, 1,   2};
        vt[6]  = '{101, 3,   1'b0, 1'b0, 101, 104};
        vt[7]  = '{102, 3,   1'b0, 1'b1, 0,   0};
        vt[8]  = '{2,   101, 1'b0, 1'b0, 2,   103};
        vt[9]  = '{2,   102, 1'b0, 1'b1, 0,   0};
        vt[10] = '{9,   4,   1'b1, 1'b0, 9,   13};

        repeat (2) @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_high", 32'(o_high), 32'd0);
        chk("rst_period", 32'(o_period), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vt[i]);

        // Timeout while waiting for a rise, then while ARM waits for a low level.
        timeout_latency(1'b0, 103, "timeout_wait_rise_latency");
        chk("timeout_busy", 32'(o_busy), 32'd0);
        timeout_latency(1'b1, 102, "timeout_arm_latency");

        // Back-to-back: restart on the o_valid cycle.
        settle_low();
        cfg_wave(1, 5);
        expect_valid(1, 6);
        pulse_start();
        c = 0;
        while (o_valid !== 1'b1 && c < 200) begin
            @(negedge i_clk);
            c++;
        end
        chk("b2b_first_valid", 32'(o_valid), 32'd1);
        i_start = 1'b1;
        expect_valid(1, 6);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("b2b_busy_no_gap", 32'(o_busy), 32'd1);
        drain("b2b");

        // Restarts while busy are ignored.
        settle_low();
        cfg_wave(4, 4);
        expect_valid(4, 8);
        pulse_start();
        repeat (3) begin
            @(negedge i_clk);
            chk("restart_busy", 32'(o_busy), 32'd1);
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
        end
        drain("restart_ignored");
        repeat (40) @(negedge i_clk);

        // Reset during HIGH discards the measurement silently.
        settle_low();
        cfg_wave(20, 20);
        expect_valid(20, 40);
        pulse_start();
        repeat (10) @(negedge i_clk);
        chk("pre_reset_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        sb.delete();
        @(negedge i_clk);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_timeout", 32'(o_timeout), 32'd0);
        chk("mid_rst_high", 32'(o_high), 32'd0);
        chk("mid_rst_period", 32'(o_period), 32'd0);
        rst = 1'b0;
        last_high = '0;
        last_period = '0;
        repeat (60) @(negedge i_clk);
        run_vec('{3, 3, 1'b0, 1'b0, 3, 6});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1, "watchdog");
    end

endmodule
